// File: rtl/zap_branch_resolve_if.sv
// Bus between the ALU stage and the branch resolve unit: pipeline inputs, resolve
// pulses, addresses, statistics and FSM debug view. clk/reset stay plain ports.
interface zap_branch_resolve_if #(
  parameter int CNT_W = 32
);
  logic             i_clear_from_writeback;
  logic             i_data_stall;
  logic             i_val;
  logic             i_branch;
  logic             i_taken;
  logic             i_cond_pass;
  logic             i_thumb;
  logic [31:0]      i_pc_plus_8;
  logic [31:0]      i_target;
  logic             i_stat_clr;
  logic             o_clear_from_alu;
  logic             o_confirm_from_alu;
  logic [31:0]      o_pc_from_alu;
  logic [31:0]      o_redirect_pc;
  logic [CNT_W-1:0] o_branch_cnt;
  logic [CNT_W-1:0] o_mispredict_cnt;
  logic             dbg_shadow;
  logic [3:0]       dbg_shadow_cnt;

  modport master (
    output i_clear_from_writeback, i_data_stall, i_val, i_branch, i_taken,
           i_cond_pass, i_thumb, i_pc_plus_8, i_target, i_stat_clr,
    input  o_clear_from_alu, o_confirm_from_alu, o_pc_from_alu, o_redirect_pc,
           o_branch_cnt, o_mispredict_cnt, dbg_shadow, dbg_shadow_cnt
  );

  modport slave (
    input  i_clear_from_writeback, i_data_stall, i_val, i_branch, i_taken,
           i_cond_pass, i_thumb, i_pc_plus_8, i_target, i_stat_clr,
    output o_clear_from_alu, o_confirm_from_alu, o_pc_from_alu, o_redirect_pc,
           o_branch_cnt, o_mispredict_cnt, dbg_shadow, dbg_shadow_cnt
  );
endinterface

// File: rtl/zap_branch_resolve.sv
// ALU-side branch resolution: registered confirm/clear pulses for the predictor and
// fetch, wrong-path suppression after a clear, and saturating branch statistics.
module zap_branch_resolve #(
  parameter int SHADOW_CYCLES = 1,
  parameter int CNT_W         = 32
) (
  input logic               i_clk,
  input logic               i_reset,
  zap_branch_resolve_if.slave bus
);

  // Handshake: a resolve is qualified by i_val & i_branch with no ready; the only
  // backpressure is i_data_stall, which freezes every register including pulses.
  typedef enum logic {ACTIVE = 1'b0, SHADOW = 1'b1} state_t;

  state_t           state, state_n;
  logic [3:0]       shadow_cnt, shadow_cnt_n;
  logic             clear_q, clear_n;
  logic             confirm_q, confirm_n;
  logic [31:0]      pc_q, pc_n;
  logic [31:0]      redirect_q, redirect_n;
  logic [CNT_W-1:0] bcnt_q, bcnt_n;
  logic [CNT_W-1:0] mcnt_q, mcnt_n;

  logic [31:0] instr_addr;
  logic [31:0] aligned_target;
  logic        resolve;
  logic        mispredict;

  assign instr_addr     = bus.i_pc_plus_8 - (bus.i_thumb ? 32'd4 : 32'd8);
  assign aligned_target = bus.i_thumb ? {bus.i_target[31:1], 1'b0}
                                      : {bus.i_target[31:2], 2'b00};
  assign resolve        = bus.i_val & bus.i_branch;
  assign mispredict     = bus.i_taken ^ bus.i_cond_pass;

  always_comb begin
    state_n      = state;
    shadow_cnt_n = shadow_cnt;
    clear_n      = 1'b0;
    confirm_n    = 1'b0;
    pc_n         = pc_q;
    redirect_n   = redirect_q;
    bcnt_n       = bcnt_q;
    mcnt_n       = mcnt_q;
    if (bus.i_clear_from_writeback) begin
      state_n      = ACTIVE;
      shadow_cnt_n = 4'd0;
      pc_n         = 32'd0;
      redirect_n   = 32'd0;
    end else if (bus.i_data_stall) begin
      clear_n   = clear_q;
      confirm_n = confirm_q;
    end else begin
      case (state)
        ACTIVE: begin
          if (resolve) begin
            pc_n = instr_addr;
            if (bcnt_q != {CNT_W{1'b1}}) bcnt_n = bcnt_q + CNT_W'(1);
            if (mispredict) begin
              clear_n      = 1'b1;
              redirect_n   = bus.i_cond_pass ? aligned_target
                                             : instr_addr + (bus.i_thumb ? 32'd2 : 32'd4);
              if (mcnt_q != {CNT_W{1'b1}}) mcnt_n = mcnt_q + CNT_W'(1);
              shadow_cnt_n = 4'(SHADOW_CYCLES);
              state_n      = SHADOW;
            end else begin
              confirm_n = 1'b1;
            end
          end
        end
        SHADOW: begin
          shadow_cnt_n = shadow_cnt - 4'd1;
          // A count of 1 reaches zero on this decrement and ends the shadow.
          if (shadow_cnt <= 4'd1) begin
            shadow_cnt_n = 4'd0;
            state_n      = ACTIVE;
          end
        end
        default: state_n = ACTIVE;
      endcase
      if (bus.i_stat_clr) begin
        bcnt_n = '0;
        mcnt_n = '0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= ACTIVE;
      shadow_cnt <= 4'd0;
      clear_q    <= 1'b0;
      confirm_q  <= 1'b0;
      pc_q       <= 32'd0;
      redirect_q <= 32'd0;
      bcnt_q     <= '0;
      mcnt_q     <= '0;
    end else begin
      state      <= state_n;
      shadow_cnt <= shadow_cnt_n;
      clear_q    <= clear_n;
      confirm_q  <= confirm_n;
      pc_q       <= pc_n;
      redirect_q <= redirect_n;
      bcnt_q     <= bcnt_n;
      mcnt_q     <= mcnt_n;
    end
  end

  assign bus.o_clear_from_alu   = clear_q;
  assign bus.o_confirm_from_alu = confirm_q;
  assign bus.o_pc_from_alu      = pc_q;
  assign bus.o_redirect_pc      = redirect_q;
  assign bus.o_branch_cnt       = bcnt_q;
  assign bus.o_mispredict_cnt   = mcnt_q;
  assign bus.dbg_shadow         = (state == SHADOW);
  assign bus.dbg_shadow_cnt     = shadow_cnt;

endmodule

// File: doc/zap_branch_resolve.md
Name: zap_branch_resolve

Overview:
- ALU-side branch resolution unit; the producer of the feedback consumed by the branch predictor and fetch.
- For each valid branch leaving the ALU, it compares the predicted taken bit with the actual condition outcome.
- Issues a registered one-cycle confirm (prediction correct) or clear (mispredict), plus the branch instruction address for predictor indexing and the redirect PC for fetch.
- Suppresses wrong-path branches after a clear and keeps saturating statistics counters.

Parameters:
SHADOW_CYCLES, 1, cycles after a clear during which incoming branches are ignored (1..15)
CNT_W, 32, width of statistics counters

Ports:
i_clk  input  1  clock
i_reset  input  1  asynchronous active-high reset
i_clear_from_writeback  input  1  pipeline flush from writeback
i_data_stall  input  1  data-side stall; freeze everything
i_val  input  1  instruction in stage is valid
i_branch  input  1  instruction is a predictable branch
i_taken  input  1  predicted-taken bit carried down from the predictor
i_cond_pass  input  1  condition evaluated true, i.e. the branch is actually taken
i_thumb  input  1  instruction is Thumb
i_pc_plus_8  input  32  instruction PC+8 (ARM) / PC+4-adjusted (Thumb) as carried in pipe
i_target  input  32  computed branch target
i_stat_clr  input  1  synchronous clear of statistics counters
o_clear_from_alu  output  1  mispredict pulse
o_confirm_from_alu  output  1  correct-prediction pulse
o_pc_from_alu  output  32  branch instruction address (predictor index source)
o_redirect_pc  output  32  fetch restart address, valid with o_clear_from_alu
o_branch_cnt  output  CNT_W  resolved branches
o_mispredict_cnt  output  CNT_W  mispredicts

Behaviour:
- Reset (async, i_reset=1): all outputs 0, state ACTIVE, shadow counter 0.
- Update priority on each i_clk edge: i_clear_from_writeback, then i_data_stall, then normal operation.
  - Writeback clear: both pulses 0, o_pc_from_alu=0, o_redirect_pc=0, state ACTIVE, shadow counter 0; statistics counters hold.
  - Data stall: all registers hold, including any pulse currently asserted.
- States:
  - ACTIVE: a resolve occurs when i_val & i_branch.
  - SHADOW: inputs are ignored and both pulses are 0. The shadow counter decrements each unstalled cycle. Return to ACTIVE when the counter reaches 0 after decrementing.
- Resolve, with outputs registered (latency 1 cycle):
  - instr_addr = i_pc_plus_8 - (i_thumb ? 4 : 8), modulo 2^32.
  - o_pc_from_alu = instr_addr.
  - mispredict = i_taken XOR i_cond_pass.
  - No mispredict: o_confirm_from_alu=1, o_clear_from_alu=0; o_redirect_pc holds its previous value.
  - Mispredict: o_clear_from_alu=1, o_confirm_from_alu=0. o_redirect_pc = i_cond_pass ? aligned target : instr_addr + (i_thumb ? 2 : 4). Aligned target clears bits [1:0] in ARM and bit [0] in Thumb. Load shadow counter with SHADOW_CYCLES and enter SHADOW.
- Non-resolve unstalled cycle in ACTIVE: both pulses 0; address outputs hold.
- Pulses never both 1. Each pulse is exactly one cycle unless extended by i_data_stall.
- Statistics counters:
  - o_branch_cnt increments on every resolve; o_mispredict_cnt increments on every mispredict.
  - Both saturate at all-ones.
  - i_stat_clr zeros both and wins over a same-cycle increment.
  - Counters do not advance during a stall or while in SHADOW.
- Address arithmetic wraps silently, e.g. 32'h4 - 8 = 32'hFFFF_FFFC.

Test Plan:
- Reset, then ARM branch with i_pc_plus_8=0x108, i_taken=1, i_cond_pass=1 -> next cycle o_confirm_from_alu=1 for 1 cycle, o_pc_from_alu=0x100, o_branch_cnt=1, o_mispredict_cnt=0.
- ARM branch with i_pc_plus_8=0x208, i_taken=0, i_cond_pass=1, i_target=0x403 -> o_clear_from_alu=1, o_redirect_pc=0x400, o_pc_from_alu=0x200. A valid branch presented the following cycle is ignored (SHADOW_CYCLES=1): no pulse and no count.
- Thumb branch with i_pc_plus_8=0x84, i_taken=1, i_cond_pass=0 -> o_clear_from_alu=1, o_pc_from_alu=0x80, o_redirect_pc=0x82, o_mispredict_cnt increments.
- Mispredict issued, then i_data_stall=1 for 3 cycles -> o_clear_from_alu stays 1 for 3 extra cycles and the shadow counter is frozen. After the stall the pulse drops and SHADOW completes one cycle later.
- Mispredict, then i_clear_from_writeback in the next cycle together with a valid branch -> outputs zeroed, state ACTIVE, no resolve. A branch in the following cycle resolves normally.
- Preload counters to 0xFFFF_FFFF via long run or force, resolve a mispredict -> both stay 0xFFFF_FFFF. Assert i_stat_clr with a simultaneous resolve -> both 0. Assert i_reset mid-SHADOW -> all outputs 0 immediately (async).
